fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Elastic instruction queue between the fetch stage and the read (decode) stage of the five-stage pipeline. It accepts PC/instruction pairs from fetch under a valid/ready handshake and holds up to DEPTH entries. It presents the oldest entry to read under the same handshake. Fetch can therefore keep running while read is stalled, and a taken branch discards every buffered wrong-path instruction in one cycle.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active low
- PC_in  in  32  PC of incoming instruction (from fetch PC_fe)
- IR_in  in  32  incoming instruction word (from fetch IR_fe)
- v_in  in  1  incoming pair is valid (from fetch v_fe)
- r_out  out  1  buffer can accept a pair this cycle (to fetch)
- PC_out  out  32  PC of head entry (to read)
- IR_out  out  32  instruction of head entry (to read)
- v_out  out  1  head entry valid (to read)
- r_in  in  1  read stage ready (r_dc)
- flush  in  1  taken-branch redirect (CP_ex && v_ex); discards all entries
- s_fb  in  1  external stall; freezes output side only
- level  out  $clog2(DEPTH)+1  current entry count

## Operation
- Storage: DEPTH x 64-bit circular array, write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0. Count cnt is $clog2(DEPTH)+1 bits.
- Occupancy states, all derived from cnt: EMPTY (cnt=0), PARTIAL (0<cnt<DEPTH), FULL (cnt=DEPTH).
- r_out = (cnt < DEPTH). This is combinational from registered cnt and does not depend on r_in or flush.
- v_out = (cnt != 0) && !s_fb && !flush.
- PC_out/IR_out are show-ahead: the head entry at rp. When EMPTY: IR_out = 32'h00000013 (NOP), PC_out = 0.
- push = v_in && r_out && !flush. A push writes {PC_in, IR_in} at wp, then wp+1.
- pop = v_out && r_in. A pop advances rp by 1.
- Next cnt = cnt + push - pop. Push and pop in the same cycle leave cnt unchanged and move both pointers; this is legal in every state except FULL, where push is impossible.
- No bypass: a pair pushed into an EMPTY buffer becomes visible on the next cycle.
- flush has priority over push and pop. On the next edge, wp=rp=0 and cnt=0. A pair offered by fetch in the flush cycle is dropped: it is a wrong-path instruction.
- s_fb blocks pops only. Pushes continue while space remains.
- Reset has priority over flush. With rst_n low at an edge: wp=rp=0, cnt=0, storage contents don't-care.
- Data is never reordered, duplicated or corrupted. Output order equals accepted input order between flushes.

## Timing
- Reset values after the first edge with rst_n=0: r_out=1, v_out=0, level=0, IR_out=32'h00000013, PC_out=0.
- Reset asserted mid-operation discards all entries exactly like flush, and reset takes precedence over flush.
- Latency: input accepted at edge N is visible on PC_out/IR_out/v_out after edge N, i.e. during cycle N+1. This is one cycle minimum, plus queueing delay.
- Throughput: one push and one pop per cycle sustained in PARTIAL.
- FULL: r_out=0 during the cycle after cnt reaches DEPTH. A pop in that cycle restores r_out=1 in the following cycle, not the same cycle.
- flush: v_out is 0 in the flush cycle itself and remains 0 the next cycle (EMPTY). First post-flush data is visible two cycles after flush rises if fetch offers it immediately after.
- level equals cnt and is registered.

## Test plan
- Reset, then stream PCs 0x00,0x04,0x08,0x0C with r_in=1 -> same four pairs leave in order, each one cycle after acceptance; level never exceeds 1.
- Hold r_in=0, offer 6 pairs, DEPTH=4 -> first 4 accepted, r_out=0 after the 4th, level=4; release r_in -> 4 pairs out in order, r_out=1 the cycle after the first pop.
- Fill to 3 entries, assert flush while v_in=1 with PC 0x40 -> level=0 next cycle, v_out=0 in flush cycle and next, PC 0x40 never appears on output.
- Push 10 pairs continuously with r_in toggling every cycle -> pointers wrap past 3, output order exact, no pair lost or duplicated.
- Assert s_fb=1 for 3 cycles with 2 entries queued and v_in=1 -> v_out=0 throughout, level rises to 4, r_out drops to 0; deassert -> head entry is the oldest PC.
- Pull rst_n low for one edge while FULL and flush=1 -> all outputs at reset values next cycle: r_out=1, v_out=0, level=0, IR_out=0x00000013.

Source files
------------

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - elastic PC/instruction queue between fetch and read stages
module fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              PC_in,
    input  logic [31:0]              IR_in,
    input  logic                     v_in,
    output logic                     r_out,
    output logic [31:0]              PC_out,
    output logic [31:0]              IR_out,
    output logic                     v_out,
    input  logic                     r_in,
    input  logic                     flush,
    input  logic                     s_fb,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0]   NOP      = 32'h0000_0013;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          empty;
    logic          push;
    logic          pop;

    assign empty  = (cnt == '0);
    assign r_out  = (cnt < FULL_CNT);
    assign v_out  = !empty && !s_fb && !flush;
    // A flush cycle accepts nothing: the offered pair is on the wrong path.
    assign push   = v_in && r_out && !flush;
    assign pop    = v_out && r_in;
    assign PC_out = empty ? 32'h0 : mem[rp][63:32];
    assign IR_out = empty ? NOP   : mem[rp][31:0];
    assign level  = cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    // Storage carries no reset; cnt alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wp] <= {PC_in, IR_in};
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - scoreboard bench for fetch_buffer
module tb_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] PC_in = '0;
    logic [31:0] IR_in = '0;
    logic        v_in = 1'b0;
    logic        r_out;
    logic [31:0] PC_out;
    logic [31:0] IR_out;
    logic        v_out;
    logic        r_in = 1'b0;
    logic        flush = 1'b0;
    logic        s_fb = 1'b0;
    logic [2:0]  level;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    logic [63:0] sb[$];

    fetch_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .PC_in(PC_in), .IR_in(IR_in), .v_in(v_in),
        .r_out(r_out), .PC_out(PC_out), .IR_out(IR_out), .v_out(v_out),
        .r_in(r_in), .flush(flush), .s_fb(s_fb), .level(level)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return (~pc) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check outputs against the scoreboard, then update it.
    task automatic step(input logic rst, input logic v, input logic [31:0] pc,
                        input logic rin, input logic fl, input logic sf);
        bit exp_r, exp_v;
        @(negedge clk);
        rst_n = rst; v_in = v; PC_in = pc; IR_in = ir_of(pc);
        r_in = rin; flush = fl; s_fb = sf;
        #1;
        exp_r = (sb.size() < 4);
        exp_v = (sb.size() != 0) && !sf && !fl;
        if (chk_en) begin
            check("r_out", {63'd0, r_out}, {63'd0, exp_r});
            check("v_out", {63'd0, v_out}, {63'd0, exp_v});
            check("level", {61'd0, level}, 64'(sb.size()));
            if (sb.size() == 0)
                check("empty_out", {PC_out, IR_out}, {32'h0, 32'h0000_0013});
            else
                check("head", {PC_out, IR_out}, sb[0]);
        end
        if (!rst || fl) begin
            sb.delete();
        end else begin
            if (exp_v && rin) void'(sb.pop_front());
            if (v && exp_r) sb.push_back({pc, ir_of(pc)});
        end
        if (!rst) chk_en = 1'b1;
    endtask

    initial begin
        // reset with flush also high
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // streaming with read ready
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // back-pressure: six offered, four accepted
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // flush with a wrong-path pair offered
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // ten pushes with read ready toggling, pointers wrap
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'h400 + 32'(i * 4), 1'(i % 2), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // stall output side with two queued
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h508 + 32'(i * 4), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // fill, then reset together with flush
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h600 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h700, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
